// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan driver with pending/active shadow words.
// Optional blinking is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_TERM     = 49999,
  parameter int COMMON_ANODE = 0
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      lz_blank,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]                Seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     dig_en,
  output logic                      frame
);

  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic INV   = (COMMON_ANODE != 0);

  logic [DIV_WIDTH-1:0]    prescaler;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_flag;
  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic tick;
  logic wrap;

  assign tick = (prescaler == DIV_WIDTH'(DIV_TERM));
  assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h73;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
    endcase
    return s;
  endfunction

`ifdef SEG7_BLINK_EN
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);
  logic [BC_W-1:0] blink_cnt;
  logic            blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`endif

  // Prescaler, scan index and the shadow pair; a load coinciding with wrap bypasses pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (wrap)
        idx <= '0;
      else if (tick)
        idx <= idx + 1'b1;

      if (load && wrap) begin
        act_val   <= value;
        act_dp    <= dp_in;
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (wrap && pend_flag) begin
        act_val   <= pend_val;
        act_dp    <= pend_dp;
        pend_flag <= 1'b0;
      end
    end
  end

  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            nib;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] dig_n;

  // upper_zero[i]: nibble i and every nibble above it are zero.
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      upper_zero[i] = ((act_val >> (4 * i)) == '0);
  end

  always_comb begin
    nib   = act_val[4*idx +: 4];
    seg_n = decode(nib);
    dp_n  = act_dp[idx];
    if (lz_blank && (idx != '0) && upper_zero[idx])
      seg_n = 7'h00;
`ifdef SEG7_BLINK_EN
    if (blink_phase && blink_mask[idx]) begin
      seg_n = 7'h00;
      dp_n  = 1'b0;
    end
`endif
    dig_n      = '0;
    dig_n[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Seg    <= {7{INV}};
      dp     <= INV;
      dig_en <= {NUM_DIGITS{INV}};
      frame  <= 1'b0;
    end else begin
      Seg    <= seg_n ^ {7{INV}};
      dp     <= dp_n ^ INV;
      dig_en <= dig_n ^ {NUM_DIGITS{INV}};
      frame  <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: common-cathode and common-anode instances share stimulus.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int DT = 3;
  localparam int P  = DT + 1;
  localparam int PN = P * N;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_blank;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] dig0, dig1;
  logic       frame0, frame1;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV_WIDTH(16), .DIV_TERM(DT), .COMMON_ANODE(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
    .Seg(seg0), .dp(dp0), .dig_en(dig0), .frame(frame0)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV_WIDTH(16), .DIV_TERM(DT), .COMMON_ANODE(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
    .Seg(seg1), .dp(dp1), .dig_en(dig1), .frame(frame1)
  );

  typedef struct {
    int         edge_no;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   k;
  logic lzCur;

  int          loadEdge[$];
  logic [15:0] loadVal[$];
  logic [3:0]  loadDp[$];

  logic [6:0] segTab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic checkOutput(input string name, input int kk, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s edge=%0d got=%h expected=%h", name, kk, act, exp);
    end
  endtask

  // Displayed word is the last load at or before the most recent completed frame boundary.
  function automatic exp_t modelAt(int kk, logic lz);
    exp_t e;
    int idx = ((kk - 1) / P) % N;
    int wrapEdge = ((kk - 1) / PN) * PN;
    logic [15:0] av = '0;
    logic [3:0]  ad = '0;
    logic [3:0]  nibv;
    foreach (loadEdge[j])
      if (loadEdge[j] <= wrapEdge) begin
        av = loadVal[j];
        ad = loadDp[j];
      end
    nibv = av[4*idx +: 4];
    e.edge_no = kk;
    e.seg     = (lz && idx > 0 && (av >> (4 * idx)) == 16'h0) ? 7'h00 : segTab[nibv];
    e.dp      = ad[idx];
    e.dig     = 4'(1 << idx);
    e.frame   = ((kk % PN) == 0);
    return e;
  endfunction

  // Called at a falling edge; drives inputs for the next rising edge and queues its expected result.
  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz);
    k++;
    load     = ld;
    value    = v;
    dp_in    = d;
    lz_blank = lz;
    lzCur    = lz;
    if (ld) begin
      loadEdge.push_back(k);
      loadVal.push_back(v);
      loadDp.push_back(d);
    end
    q.push_back(modelAt(k, lz));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 16'h0, 4'h0, lzCur);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_seg0"},   k, {1'b0, seg0}, 8'h00);
    checkOutput({tag, "_dp0"},    k, {7'b0, dp0},  8'h00);
    checkOutput({tag, "_dig0"},   k, {4'b0, dig0}, 8'h00);
    checkOutput({tag, "_frame0"}, k, {7'b0, frame0}, 8'h00);
    checkOutput({tag, "_seg1"},   k, {1'b0, seg1}, 8'h7F);
    checkOutput({tag, "_dp1"},    k, {7'b0, dp1},  8'h01);
    checkOutput({tag, "_dig1"},   k, {4'b0, dig1}, 8'h0F);
    checkOutput({tag, "_frame1"}, k, {7'b0, frame1}, 8'h00);
  endtask

  // Monitor: one queued expectation per rising edge outside reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        checkOutput("seg",    e.edge_no, {1'b0, seg0},   {1'b0, e.seg});
        checkOutput("dp",     e.edge_no, {7'b0, dp0},    {7'b0, e.dp});
        checkOutput("dig_en", e.edge_no, {4'b0, dig0},   {4'b0, e.dig});
        checkOutput("frame",  e.edge_no, {7'b0, frame0}, {7'b0, e.frame});
        checkOutput("seg_ca",    e.edge_no, {1'b0, seg1},   {1'b0, ~e.seg});
        checkOutput("dp_ca",     e.edge_no, {7'b0, dp1},    {7'b0, ~e.dp});
        checkOutput("dig_en_ca", e.edge_no, {4'b0, dig1},   {4'b0, ~e.dig});
        checkOutput("frame_ca",  e.edge_no, {7'b0, frame1}, {7'b0, e.frame});
      end
    end
  end

  initial begin
    logic [15:0] v;
    logic        ld;
    int          sel;
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    lz_blank = 1'b0;
    lzCur    = 1'b0;
    k        = 0;
    repeat (3) @(negedge clk);
    #1 checkReset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed: idle frames, mid-frame load, load on the wrap edge, dp with blanked zeros.
    idle(21);
    applyStimulus(1'b1, 16'h1A3F, 4'h0, 1'b0);
    idle(25);
    applyStimulus(1'b1, 16'h0005, 4'h0, 1'b1);
    idle(20);
    applyStimulus(1'b1, 16'h0000, 4'b0100, 1'b1);
    idle(16);
    applyStimulus(1'b1, 16'h00C0, 4'b1001, 1'b1);
    applyStimulus(1'b1, 16'h0B07, 4'b0010, 1'b1);
    idle(40);

    // Reset mid-frame: outputs drop at once, then scanning restarts with a cleared word.
    applyStimulus(1'b1, 16'h4321, 4'hF, 1'b0);
    idle(5);
    rst = 1'b1;
    q.delete();
    #1 checkReset("midreset");
    loadEdge.delete();
    loadVal.delete();
    loadDp.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    idle(20);

    // Randomized: sparse loads, extra weight on frame-boundary edges, occasional lz toggles.
    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 4);
      v   = 16'($urandom);
      case (sel)
        0: v &= 16'h000F;
        1: v &= 16'h00FF;
        2: v &= 16'h0FFF;
        3: v = 16'h0000;
        default: ;
      endcase
      if (((k + 1) % PN) == 0)
        ld = ($urandom_range(0, 2) == 0);
      else
        ld = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0)
        lzCur = ~lzCur;
      applyStimulus(ld, v, 4'($urandom), lzCur);
    end

    @(posedge clk);
    #2;
    checkOutput("queue_drained", k, 8'(q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed driver for a NUM_DIGITS-digit seven-segment display.
- Accepts a packed hex word plus per-digit decimal points through a load strobe. Holds the word in a pending/active shadow pair so a frame never shows a mix of old and new digits.
- Scans the digits at a prescaled rate and decodes each nibble to segments on a shared segment bus.
- Sits between the datapath registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DIV_WIDTH, 16, width of the refresh prescaler counter.
- DIV_TERM, 49999, prescaler terminal count. A scan tick occurs every DIV_TERM+1 clocks. Must satisfy DIV_TERM < 2**DIV_WIDTH.
- COMMON_ANODE, 0, 0 means Seg/dp/dig_en are active-high. 1 means all three are inverted (active-low).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  capture value/dp_in this cycle
- value  in  4*NUM_DIGITS  hex digits; nibble i drives digit i, digit 0 least significant
- dp_in  in  NUM_DIGITS  decimal point request per digit
- lz_blank  in  1  leading-zero blanking enable (level, sampled every cycle)
- Seg  out  7  segments, bit6=a ... bit0=g
- dp  out  1  decimal point of the currently selected digit
- dig_en  out  NUM_DIGITS  one-hot digit select
- frame  out  1  one-cycle pulse when the scan wraps back to digit 0

Behaviour:
- Clock and reset:
  - Single clock domain. rst is asynchronous and active-high.
  - All registers clear on rst: prescaler=0, idx=0, pending=0, active=0, pend_flag=0.
  - Output levels during and after reset: Seg, dp and dig_en at their inactive level (all 0 if COMMON_ANODE=0, all 1 if 1), frame=0.
- Prescaler:
  - Counts 0..DIV_TERM and wraps to 0.
  - tick is asserted in the cycle the count equals DIV_TERM.
- Scan index:
  - idx increments on tick. At NUM_DIGITS-1 it wraps to 0 instead.
  - wrap = tick AND idx==NUM_DIGITS-1.
- Shadow registers:
  - load=1 without wrap: pending<=value/dp_in, pend_flag<=1.
  - wrap without load: if pend_flag, active<=pending and pend_flag<=0; otherwise active holds.
  - load and wrap in the same cycle: active<=value/dp_in directly (bypass), and pending is loaded with the same value. pend_flag<=0.
  - Repeated loads within one frame: the last one wins.
- Outputs, all registered:
  - Seg, dp and dig_en reflect the new idx/active exactly one clock after the register update.
  - frame is a registered copy of wrap, so it is high for one clock, one cycle after wrap.
- Decode, active-high form before polarity:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=73, A=77, b=1F, C=4E, d=3D, E=4F, F=47 (hex)
- Leading-zero blanking:
  - Applies when lz_blank=1 and digit i>0.
  - Digit i is blanked (Seg=00 active-high) if nibble i and all higher nibbles of active are 0.
  - Digit 0 is never blanked.
  - dp is still driven from active dp even on a blanked digit.
- Polarity: COMMON_ANODE=1 inverts Seg, dp and dig_en at the output register input. Reset levels follow the same inversion.
- Reset mid-frame: outputs go inactive immediately. Scanning restarts at digit 0 with active=0.

Optional Feature:
- Macro SEG7_BLINK_EN.
- When defined:
  - Adds input blink_mask [NUM_DIGITS] and a parameter BLINK_FRAMES (default 64).
  - A frame counter toggles a blink phase every BLINK_FRAMES wraps. Counter and phase clear on rst.
  - While the phase is 1, any digit whose blink_mask bit is set shows all segments and dp inactive. dig_en is unaffected.
- When not defined: no port, no counter, and behaviour is identical to the feature being absent.

Test Plan (NUM_DIGITS=4, DIV_TERM=3, COMMON_ANODE=0 unless stated):
- Reset release: rst high then low → Seg=00, dp=0, dig_en=0000 during reset. First tick at clock 4. One cycle later dig_en=0010, Seg=7E (digit 1 of value 0).
- Load 16'h1A3F at mid-frame → display unchanged until wrap. On the frame pulse, active=1A3F. The scan then shows 47, 79, 77, 30 on dig_en 0001, 0010, 0100, 1000.
- Load and wrap in the same cycle with 16'h0005 and lz_blank=1 → the immediately following frame shows digit0 Seg=5B. Digits 1..3 show Seg=00 with dig_en still cycling.
- dp_in=4'b0100 with value 16'h0000 and lz_blank=1 → digit 2 shows Seg=00, dp=1. Digit 0 shows 7E.
- COMMON_ANODE=1, value 16'h8888 → Seg=00, and dig_en is the inverted one-hot (e.g. 1110). During reset all outputs are 1.
- SEG7_BLINK_EN with BLINK_FRAMES=2, blink_mask=0001 → digit 0 segments go dark for 2 frames, lit for 2 frames, repeating. Other digits are unaffected.
